// File: rtl/alu_wb_buffer.sv
// Writeback buffer between a registered ALU stage and a shared writeback port.
// Holds up to DEPTH results in order; flushed entries are dropped at the head without writeback.
module alu_wb_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [91:0]              IN_uop,
    output logic                     OUT_wbStall,
    input  logic                     IN_invalidate,
    input  logic [5:0]               IN_invalidateSqN,
    input  logic                     IN_portGrant,
    output logic                     OUT_wbValid,
    output logic [31:0]              OUT_wbResult,
    output logic [5:0]               OUT_wbTag,
    output logic [4:0]               OUT_wbNmDst,
    output logic [5:0]               OUT_wbSqN,
    output logic [1:0]               OUT_wbFlags,
    output logic [$clog2(DEPTH):0]   OUT_occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned CMP_W = OCC_W + 1;
    localparam int unsigned SQN_W = 6;

    typedef struct packed {
        logic [31:0]      result;
        logic [5:0]       tag;
        logic [4:0]       nm_dst;
        logic [SQN_W-1:0] sqn;
        logic [1:0]       flags;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [DEPTH-1:0]   live_q, live_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [OCC_W-1:0]   occ_q, occ_d;

    entry_t             in_entry_c;
    entry_t             head_entry_c;
    logic               head_kill_c;
    logic               wb_valid_c;
    logic               pop_c;
    logic               enq_c;
    logic               unused_uop_bits;

    // Sequence numbers wrap at 64; "younger" means strictly ahead of the bound in 6-bit signed distance.
    function automatic logic is_younger(input logic [SQN_W-1:0] sqn, input logic [SQN_W-1:0] bound);
        logic [SQN_W-1:0] diff;
        diff = sqn - bound;
        return $signed(diff) > 6'sd0;
    endfunction

    assign in_entry_c = '{
        result: IN_uop[91:60],
        tag:    IN_uop[59:54],
        nm_dst: IN_uop[53:49],
        sqn:    IN_uop[48:43],
        flags:  IN_uop[2:1]
    };
    assign unused_uop_bits = ^IN_uop[42:3];

    always_comb begin
        head_entry_c = mem_q[head_q];
        head_kill_c  = IN_invalidate && is_younger(head_entry_c.sqn, IN_invalidateSqN);
        wb_valid_c   = rst && (occ_q != '0) && live_q[head_q] && !head_kill_c;
        // A non-presentable head (dead or being killed) is dropped without waiting for a grant.
        pop_c        = (occ_q != '0) && (!wb_valid_c || IN_portGrant);
        enq_c        = rst && IN_uop[0] && !(IN_invalidate && is_younger(IN_uop[48:43], IN_invalidateSqN));
    end

    always_comb begin
        live_d = live_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (IN_invalidate) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (is_younger(mem_q[i].sqn, IN_invalidateSqN)) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (pop_c) begin
            live_d[head_q] = 1'b0;
            head_d         = head_q + PTR_W'(1);
        end
        // Enqueue last so a full-buffer pop+push into the same slot leaves it live.
        if (enq_c) begin
            live_d[tail_q] = 1'b1;
            tail_d         = tail_q + PTR_W'(1);
        end
        occ_d = occ_q + OCC_W'(enq_c) - OCC_W'(pop_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            live_q <= live_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Payload storage needs no reset: the live bits and occupancy gate its visibility.
    always_ff @(posedge clk) begin
        if (enq_c) begin
            mem_q[tail_q] <= in_entry_c;
        end
    end

    assign OUT_wbStall   = !rst || ((CMP_W'(occ_q) + CMP_W'(IN_uop[0])) >= CMP_W'(DEPTH));
    assign OUT_wbValid   = wb_valid_c;
    assign OUT_wbResult  = head_entry_c.result;
    assign OUT_wbTag     = head_entry_c.tag;
    assign OUT_wbNmDst   = head_entry_c.nm_dst;
    assign OUT_wbSqN     = head_entry_c.sqn;
    assign OUT_wbFlags   = head_entry_c.flags;
    assign OUT_occupancy = occ_q;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Bench for alu_wb_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed writeback sequences.
module tb_alu_wb_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [91:0] IN_uop = '0;
    logic        IN_invalidate = 1'b0;
    logic [5:0]  IN_invalidateSqN = '0;
    logic        IN_portGrant = 1'b0;
    logic        OUT_wbStall;
    logic        OUT_wbValid;
    logic [31:0] OUT_wbResult;
    logic [5:0]  OUT_wbTag;
    logic [4:0]  OUT_wbNmDst;
    logic [5:0]  OUT_wbSqN;
    logic [1:0]  OUT_wbFlags;
    logic [2:0]  OUT_occupancy;

    alu_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .IN_uop(IN_uop),
        .OUT_wbStall(OUT_wbStall),
        .IN_invalidate(IN_invalidate),
        .IN_invalidateSqN(IN_invalidateSqN),
        .IN_portGrant(IN_portGrant),
        .OUT_wbValid(OUT_wbValid),
        .OUT_wbResult(OUT_wbResult),
        .OUT_wbTag(OUT_wbTag),
        .OUT_wbNmDst(OUT_wbNmDst),
        .OUT_wbSqN(OUT_wbSqN),
        .OUT_wbFlags(OUT_wbFlags),
        .OUT_occupancy(OUT_occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  sq;
        logic [31:0] res;
        logic [5:0]  tag;
        logic [4:0]  nm;
        logic [1:0]  fl;
        bit          live;
    } ent_t;

    ent_t       mq[$];
    logic [5:0] wb_log[$];
    int         n_checks = 0;
    int         n_fail = 0;
    bit         last_stall = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Younger = strictly ahead of bound by 1..31 positions on the 64-entry sequence ring.
    function automatic bit younger(input logic [5:0] a, input logic [5:0] b);
        int d;
        d = (int'(a) - int'(b) + 64) % 64;
        return (d >= 1) && (d <= 31);
    endfunction

    function automatic bit model_valid();
        if (mq.size() == 0) return 1'b0;
        return mq[0].live && !(IN_invalidate && younger(mq[0].sq, IN_invalidateSqN));
    endfunction

    function automatic logic [91:0] mk_uop(input bit v, input logic [5:0] sq, input logic [31:0] res);
        logic [91:0] u;
        u        = '0;
        u[91:60] = res;
        u[59:54] = sq + 6'd2;
        u[53:49] = sq[4:0] ^ 5'h11;
        u[48:43] = sq;
        u[42:11] = 32'hC0DE_0000 | 32'(sq);
        u[10:3]  = 8'h5A;
        u[2:1]   = sq[1:0];
        u[0]     = v;
        return u;
    endfunction

    // Model state update: same-edge kill, at most one pop and one push.
    bit   m_hv, m_pop, m_enq;
    ent_t m_e;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
        end else begin
            m_hv  = model_valid();
            m_pop = (mq.size() != 0) && (!m_hv || IN_portGrant);
            m_enq = IN_uop[0] && !(IN_invalidate && younger(IN_uop[48:43], IN_invalidateSqN));
            if (m_enq) check("no_overflow", 32'(mq.size() == DEPTH && !m_pop), 32'd0);
            if (IN_invalidate) begin
                foreach (mq[i]) begin
                    if (younger(mq[i].sq, IN_invalidateSqN)) begin
                        m_e = mq[i];
                        m_e.live = 1'b0;
                        mq[i] = m_e;
                    end
                end
            end
            if (m_pop) void'(mq.pop_front());
            if (m_enq) begin
                m_e.sq   = IN_uop[48:43];
                m_e.res  = IN_uop[91:60];
                m_e.tag  = IN_uop[59:54];
                m_e.nm   = IN_uop[53:49];
                m_e.fl   = IN_uop[2:1];
                m_e.live = 1'b1;
                mq.push_back(m_e);
            end
        end
    end

    // Compare outputs against the model mid-cycle, away from the active edge.
    bit c_ev, c_es;
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_stall", 32'(OUT_wbStall), 32'd1);
            check("rst_valid", 32'(OUT_wbValid), 32'd0);
            check("rst_occ",   32'(OUT_occupancy), 32'd0);
            last_stall = 1'b1;
        end else begin
            c_ev = model_valid();
            c_es = (int'(mq.size()) + int'(IN_uop[0])) >= int'(DEPTH);
            check("valid", 32'(OUT_wbValid), 32'(c_ev));
            check("occupancy", 32'(OUT_occupancy), 32'(mq.size()));
            check("stall", 32'(OUT_wbStall), 32'(c_es));
            if (c_ev) begin
                check("result", OUT_wbResult, mq[0].res);
                check("tag",    32'(OUT_wbTag),   32'(mq[0].tag));
                check("nmdst",  32'(OUT_wbNmDst), 32'(mq[0].nm));
                check("sqn",    32'(OUT_wbSqN),   32'(mq[0].sq));
                check("flags",  32'(OUT_wbFlags), 32'(mq[0].fl));
            end
            if (OUT_wbValid && IN_portGrant) wb_log.push_back(OUT_wbSqN);
            last_stall = c_es;
        end
    end

    task automatic drive(input bit v, input logic [5:0] sq, input bit inv, input logic [5:0] isq, input bit g);
        IN_uop           = mk_uop(v, sq, 32'hA000_0000 | 32'(sq));
        IN_invalidate    = inv;
        IN_invalidateSqN = isq;
        IN_portGrant     = g;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enqueue(input logic [5:0] sq);
        drive(1'b1, sq, 1'b0, 6'd0, 1'b0);
        tick();
    endtask

    logic [5:0] sq_ctr;
    bit         rv, rg, ri;

    initial begin
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Single result with grant held.
        wb_log.delete();
        IN_uop = mk_uop(1'b1, 6'd3, 32'h1234_5678);
        IN_portGrant = 1'b1;
        tick();
        check("t1_occ1",   32'(OUT_occupancy), 32'd1);
        check("t1_valid",  32'(OUT_wbValid), 32'd1);
        check("t1_result", OUT_wbResult, 32'h1234_5678);
        check("t1_tag",    32'(OUT_wbTag), 32'd5);
        check("t1_sqn",    32'(OUT_wbSqN), 32'd3);
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
        tick();
        check("t1_occ0",   32'(OUT_occupancy), 32'd0);
        check("t1_log_n",  32'(wb_log.size()), 32'd1);
        check("t1_log0",   32'(wb_log[0]), 32'd3);

        // Fill with grant low.
        wb_log.delete();
        enqueue(6'd1);
        enqueue(6'd2);
        enqueue(6'd3);
        check("t2_occ3", 32'(OUT_occupancy), 32'd3);
        drive(1'b1, 6'd4, 1'b0, 6'd0, 1'b0);
        #1;
        check("t2_stall_at_3", 32'(OUT_wbStall), 32'd1);
        tick();
        check("t2_occ4", 32'(OUT_occupancy), 32'd4);
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        #1;
        check("t2_stall_full", 32'(OUT_wbStall), 32'd1);

        // Drain in order on consecutive cycles.
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
        check("t3_head1", 32'(OUT_wbSqN), 32'd1);
        tick();
        check("t3_head2", 32'(OUT_wbSqN), 32'd2);
        tick();
        check("t3_head3", 32'(OUT_wbSqN), 32'd3);
        tick();
        check("t3_head4", 32'(OUT_wbSqN), 32'd4);
        tick();
        check("t3_occ0",  32'(OUT_occupancy), 32'd0);
        check("t3_log_n", 32'(wb_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("t3_log", 32'(wb_log[i]), 32'(i + 1));

        // Flush keeps only the boundary entry.
        wb_log.delete();
        enqueue(6'd10);
        enqueue(6'd11);
        enqueue(6'd12);
        drive(1'b0, 6'd0, 1'b1, 6'd10, 1'b1);
        #1;
        check("t4_valid10", 32'(OUT_wbValid), 32'd1);
        check("t4_sqn10",   32'(OUT_wbSqN), 32'd10);
        tick();
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
        #1;
        check("t4_dead_valid", 32'(OUT_wbValid), 32'd0);
        check("t4_occ2",       32'(OUT_occupancy), 32'd2);
        tick();
        check("t4_occ1", 32'(OUT_occupancy), 32'd1);
        tick();
        check("t4_occ0",  32'(OUT_occupancy), 32'd0);
        check("t4_log_n", 32'(wb_log.size()), 32'd1);
        check("t4_log0",  32'(wb_log[0]), 32'd10);

        // Flush across the sequence-number wrap; incoming sqN=1 is killed too.
        wb_log.delete();
        enqueue(6'd62);
        enqueue(6'd63);
        enqueue(6'd0);
        drive(1'b1, 6'd1, 1'b1, 6'd63, 1'b0);
        tick();
        check("t5_occ3", 32'(OUT_occupancy), 32'd3);
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
        repeat (3) tick();
        check("t5_occ0",  32'(OUT_occupancy), 32'd0);
        check("t5_log_n", 32'(wb_log.size()), 32'd2);
        check("t5_log0",  32'(wb_log[0]), 32'd62);
        check("t5_log1",  32'(wb_log[1]), 32'd63);

        // Reset mid-fill discards everything.
        wb_log.delete();
        enqueue(6'd20);
        enqueue(6'd21);
        enqueue(6'd22);
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("t6_rst_occ",   32'(OUT_occupancy), 32'd0);
        check("t6_rst_valid", 32'(OUT_wbValid), 32'd0);
        check("t6_rst_stall", 32'(OUT_wbStall), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("t6_post_stall", 32'(OUT_wbStall), 32'd0);
        check("t6_post_valid", 32'(OUT_wbValid), 32'd0);
        tick();
        check("t6_log_n", 32'(wb_log.size()), 32'd0);

        // Mixed traffic honouring backpressure; the per-cycle compare does the checking.
        sq_ctr = 6'd30;
        for (int n = 0; n < 400; n++) begin
            rv = !last_stall && ($urandom_range(0, 2) != 0);
            rg = ($urandom_range(0, 3) != 0);
            ri = ($urandom_range(0, 9) == 0);
            drive(rv, sq_ctr, ri, sq_ctr - 6'($urandom_range(0, 5)), rg);
            if (rv) sq_ctr = sq_ctr + 6'd1;
            tick();
        end
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
        repeat (6) tick();
        check("final_occ0", 32'(OUT_occupancy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
